line_points: RTL and testbench
==============================

# line_points

Parametrised point-stream generator: given two endpoints, emits every integer point of the Bresenham line between them, one point per accepted beat. It belongs to the generator-derived module family. Unlike the fixed two-beat endpoint emitter, it supports any coordinate width, an arbitrary number of output beats, consumer back-pressure (valid/ready), restart on `_start` and asynchronous reset. It sits between a shape-description source and the pixel/framebuffer writer.

## Interface
- `WIDTH`, default 32: signed width of coordinates and of `_out0`/`_out1`; must be ≥ 4.
- `_clock`  in  1  rising-edge clock.
- `_reset_n`  in  1  asynchronous, active-low reset.
- `_start`  in  1  synchronous; when high, latches endpoints and (re)starts generation.
- `x0`, `y0`, `x1`, `y1`  in  WIDTH signed  endpoints; sampled only on the `_start` edge.
- `_ready`  in  1  consumer can accept the current point.
- `_out0`  out  WIDTH signed  point x.
- `_out1`  out  WIDTH signed  point y.
- `_valid`  out  1  `_out0`/`_out1` hold a point.
- `_done`  out  1  all points have been transferred; held until the next `_start`.

## Operation
- Reset (`_reset_n` low, any time, asynchronous): state IDLE; `_out0=0`, `_out1=0`, `_valid=0`, `_done=0`; all internal registers 0.
- States: IDLE, INIT, EMIT, DONE.
- `_start` high at any edge, in any state: latch endpoints, `_valid<=0`, `_done<=0`, go to INIT. `_start` has priority over every other transition. A beat with `_valid & _ready` on that same edge still counts as transferred under the protocol; the rest of the old line is abandoned.
- INIT (one cycle):
  - `dx=|x1-x0|`, `dy=-|y1-y0|`.
  - `sx=+1` if `x0<x1`, else `-1`; `sy=+1` if `y0<y1`, else `-1`.
  - `err=dx+dy`, `x=x0`, `y=y0`.
  - Drive `_out0=x0`, `_out1=y0`, `_valid<=1`, go to EMIT.
- EMIT, on an edge with `_valid & _ready`:
  - Current point equals (x1,y1): `_valid<=0`, `_done<=1`, go to DONE.
  - Otherwise, with `e2=2*err`:
    - if `e2>=dy`: `err+=dy`, `x+=sx`;
    - if `e2<=dx`: `err+=dx`, `y+=sy`.
    - Both updates use the pre-step `err`/`e2`. Present the new point; `_valid` stays 1.
- EMIT with `_valid & !_ready`: all outputs and internal state hold exactly.
- DONE: `_done=1`, `_valid=0`; stays here until `_start`.
- IDLE: `_ready` is ignored.
- Widths:
  - `dx`, `dy`, `err` are WIDTH+2 signed; `e2` is WIDTH+3 signed.
  - Endpoint differences are computed after sign-extension, so no overflow occurs for any legal endpoints.
  - `x`/`y` never leave the endpoint bounding box.
- Point count is `max(dx,-dy)+1`. A degenerate line (x0=x1, y0=y1) emits exactly one point.

## Timing
- `_start` sampled at edge k → INIT after k → first `_valid=1` after edge k+1.
- With `_ready` held high: one point per cycle. For an N-point line, the last point is transferred at edge k+1+N, and `_done` is high after that edge.
- Outputs are registered. There is no combinational path from `_ready` to `_out0`, `_out1` or `_valid`.
- `_done` rises on the edge that transfers the final point. `_valid` falls on the same edge.

## Test plan
- Horizontal, `WIDTH=32`, (0,0)→(3,0), `_ready`=1:
  - beats (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles starting 2 cycles after `_start`;
  - `_done`=1 on the next cycle and held.
- Negative octant, (2,1)→(-1,-1):
  - exactly (2,1),(1,0),(0,0),(-1,-1), then `_done`.
- Degenerate, (5,5)→(5,5):
  - one beat (5,5), then `_valid`=0, `_done`=1.
- Back-pressure, (0,0)→(2,5), `_ready` pseudo-random:
  - outputs stable while `_ready`=0;
  - transferred sequence equals the `_ready`=1 sequence: (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- `WIDTH=8`, (-128,-128)→(127,127):
  - 256 beats, all (i,i) for i=-128..127, no wrap.
- Abort cases:
  - Restart: `_start` asserted mid-line (after 2 beats) with new endpoints (0,0)→(0,2): old line abandoned, new sequence (0,0),(0,1),(0,2).
  - Reset: `_reset_n` pulsed low mid-line: all outputs 0 immediately (asynchronously), IDLE until the next `_start`.

Source files
------------

// File: rtl/line_points.sv
// line_points: Bresenham point-stream generator.
// Latches two endpoints on _start and emits every integer point of the line
// between them, one point per accepted valid/ready beat.
//
// Ports:
//   _clock           rising-edge clock
//   _reset_n         asynchronous active-low reset
//   _start           latch endpoints and (re)start generation; wins over all else
//   x0, y0, x1, y1   signed endpoints, sampled only when _start is high
//   _ready           consumer accepts the current point
//   _out0, _out1     current point (x, y), registered
//   _valid           _out0/_out1 hold a point
//   _done            every point transferred; held until the next _start
module line_points #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] y1,
    input  logic                    _ready,
    output logic signed [WIDTH-1:0] _out0,
    output logic signed [WIDTH-1:0] _out1,
    output logic                    _valid,
    output logic                    _done
);

    // Two guard bits keep |x1-x0| and err = dx + dy exact for any endpoints.
    localparam int W2 = WIDTH + 2;
    localparam int W3 = WIDTH + 3;
    localparam logic signed [WIDTH-1:0] One = 1;

    typedef enum logic [1:0] {StIdle, StInit, StEmit, StDone} state_e;

    state_e                  r_state, w_state;
    logic signed [WIDTH-1:0] r_x0, r_y0, r_x1, r_y1;
    logic signed [WIDTH-1:0] w_x0, w_y0, w_x1, w_y1;
    logic signed [W2-1:0]    r_dx, r_dy, r_err;
    logic signed [W2-1:0]    w_dx, w_dy, w_err;
    logic                    r_sx_neg, r_sy_neg, w_sx_neg, w_sy_neg;
    logic signed [WIDTH-1:0] r_x, r_y, w_x, w_y;
    logic                    r_valid, r_done, w_valid, w_done;

    logic signed [W2-1:0]    w_ddx, w_ddy, w_adx, w_ady;
    logic signed [W3-1:0]    w_e2;
    logic                    w_step_x, w_step_y, w_at_end;

    always_comb begin
        w_ddx    = W2'(r_x1) - W2'(r_x0);
        w_ddy    = W2'(r_y1) - W2'(r_y0);
        w_adx    = w_ddx[W2-1] ? -w_ddx : w_ddx;
        w_ady    = w_ddy[W2-1] ? -w_ddy : w_ddy;
        w_e2     = $signed({r_err, 1'b0});
        // Both step decisions come from the pre-step error term.
        w_step_x = (w_e2 >= W3'(r_dy));
        w_step_y = (w_e2 <= W3'(r_dx));
        w_at_end = (r_x == r_x1) && (r_y == r_y1);
    end

    always_comb begin
        w_state  = r_state;
        w_x0     = r_x0;
        w_y0     = r_y0;
        w_x1     = r_x1;
        w_y1     = r_y1;
        w_dx     = r_dx;
        w_dy     = r_dy;
        w_err    = r_err;
        w_sx_neg = r_sx_neg;
        w_sy_neg = r_sy_neg;
        w_x      = r_x;
        w_y      = r_y;
        w_valid  = r_valid;
        w_done   = r_done;

        unique case (r_state)
            StIdle: ;
            StInit: begin
                w_dx     = w_adx;
                w_dy     = -w_ady;
                w_err    = w_adx - w_ady;
                w_sx_neg = !(r_x0 < r_x1);
                w_sy_neg = !(r_y0 < r_y1);
                w_x      = r_x0;
                w_y      = r_y0;
                w_valid  = 1'b1;
                w_state  = StEmit;
            end
            StEmit: begin
                if (r_valid && _ready) begin
                    if (w_at_end) begin
                        w_valid = 1'b0;
                        w_done  = 1'b1;
                        w_state = StDone;
                    end else begin
                        if (w_step_x) begin
                            w_err = w_err + r_dy;
                            w_x   = r_sx_neg ? r_x - One : r_x + One;
                        end
                        if (w_step_y) begin
                            w_err = w_err + r_dx;
                            w_y   = r_sy_neg ? r_y - One : r_y + One;
                        end
                    end
                end
            end
            StDone: ;
            default: w_state = StIdle;
        endcase

        if (_start) begin
            w_x0    = x0;
            w_y0    = y0;
            w_x1    = x1;
            w_y1    = y1;
            w_valid = 1'b0;
            w_done  = 1'b0;
            w_state = StInit;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            r_state  <= StIdle;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_x0     <= w_x0;
            r_y0     <= w_y0;
            r_x1     <= w_x1;
            r_y1     <= w_y1;
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_err    <= w_err;
            r_sx_neg <= w_sx_neg;
            r_sy_neg <= w_sy_neg;
            r_x      <= w_x;
            r_y      <= w_y;
            r_valid  <= w_valid;
            r_done   <= w_done;
        end
    end

    assign _out0  = r_x;
    assign _out1  = r_y;
    assign _valid = r_valid;
    assign _done  = r_done;

endmodule

// File: tb/tb_line_points.sv
// Directed bench for line_points: a 32-bit and an 8-bit instance share all
// inputs; sel8 chooses which instance's outputs are observed.
module tb_line_points;

    logic clk = 1'b0;
    logic rst_n, start, rdy;
    int   ax0, ay0, ax1, ay1;
    bit   sel8;

    logic signed [31:0] o0, o1;
    logic               v32, d32;
    logic signed [7:0]  p0, p1;
    logic               v8, d8;

    int   obs_x, obs_y;
    logic obs_v, obs_d;

    int   ex[$];
    int   ey[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    line_points #(.WIDTH(32)) u_dut (
        ._clock(clk), ._reset_n(rst_n), ._start(start),
        .x0(ax0), .y0(ay0), .x1(ax1), .y1(ay1),
        ._ready(rdy), ._out0(o0), ._out1(o1), ._valid(v32), ._done(d32)
    );

    line_points #(.WIDTH(8)) u_dut8 (
        ._clock(clk), ._reset_n(rst_n), ._start(start),
        .x0(ax0[7:0]), .y0(ay0[7:0]), .x1(ax1[7:0]), .y1(ay1[7:0]),
        ._ready(rdy), ._out0(p0), ._out1(p1), ._valid(v8), ._done(d8)
    );

    always_comb begin
        obs_x = sel8 ? int'(p0) : int'(o0);
        obs_y = sel8 ? int'(p1) : int'(o1);
        obs_v = sel8 ? v8 : v32;
        obs_d = sel8 ? d8 : d32;
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic start_line(input string tag, input int a, input int b,
                              input int c, input int d);
        @(negedge clk);
        start = 1'b1;
        ax0 = a; ay0 = b; ax1 = c; ay1 = d;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_init_valid"}, obs_v, 0);
        check({tag, "_init_done"}, obs_d, 0);
    endtask

    // Consumes n_beats points against ex/ey; rnd selects a stalling ready pattern.
    task automatic run_line(input string tag, input bit rnd, input int n_beats,
                            input bit full);
        int          idx = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        int          px = 0;
        int          py = 0;
        logic [31:0] pat = 32'hB4D2_6A39;
        while (idx < n_beats && cyc < 600) begin
            @(negedge clk);
            if (stalled) begin
                check({tag, "_hold_x"}, obs_x, px);
                check({tag, "_hold_y"}, obs_y, py);
                check({tag, "_hold_v"}, obs_v, 1);
            end
            stalled = 1'b0;
            rdy = rnd ? pat[cyc % 32] : 1'b1;
            cyc++;
            if (obs_v) begin
                if (rdy) begin
                    check({tag, "_x"}, obs_x, ex[idx]);
                    check({tag, "_y"}, obs_y, ey[idx]);
                    idx++;
                end else begin
                    stalled = 1'b1;
                    px = obs_x;
                    py = obs_y;
                end
            end
        end
        check({tag, "_beats"}, idx, n_beats);
        if (full) begin
            if (!rnd) check({tag, "_cycles"}, cyc, n_beats);
            @(negedge clk);
            check({tag, "_done"}, obs_d, 1);
            check({tag, "_valid_low"}, obs_v, 0);
            repeat (2) @(negedge clk);
            check({tag, "_done_held"}, obs_d, 1);
            check({tag, "_valid_held"}, obs_v, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rdy   = 1'b0;
        sel8  = 1'b0;
        ax0 = 0; ay0 = 0; ax1 = 0; ay1 = 0;
        #12;
        check("rst_x", obs_x, 0);
        check("rst_y", obs_y, 0);
        check("rst_valid", obs_v, 0);
        check("rst_done", obs_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy   = 1'b1;

        // Horizontal
        start_line("horiz", 0, 0, 3, 0);
        ex = '{0, 1, 2, 3};
        ey = '{0, 0, 0, 0};
        run_line("horiz", 1'b0, 4, 1'b1);

        // Negative octant
        start_line("negoct", 2, 1, -1, -1);
        ex = '{2, 1, 0, -1};
        ey = '{1, 0, 0, -1};
        run_line("negoct", 1'b0, 4, 1'b1);

        // Degenerate
        start_line("degen", 5, 5, 5, 5);
        ex = '{5};
        ey = '{5};
        run_line("degen", 1'b0, 1, 1'b1);

        // Back-pressure
        start_line("bp", 0, 0, 2, 5);
        ex = '{0, 0, 1, 1, 2, 2};
        ey = '{0, 1, 2, 3, 4, 5};
        run_line("bp", 1'b1, 6, 1'b1);

        // Restart mid-line
        rdy = 1'b1;
        start_line("rs_old", 0, 0, 5, 3);
        ex = '{0, 1};
        ey = '{0, 1};
        run_line("rs_old", 1'b0, 2, 1'b0);
        start_line("rs_new", 0, 0, 0, 2);
        ex = '{0, 0, 0};
        ey = '{0, 1, 2};
        run_line("rs_new", 1'b0, 3, 1'b1);

        // Asynchronous reset mid-line
        start_line("ar", 0, 0, 3, 0);
        ex = '{0, 1};
        ey = '{0, 0};
        run_line("ar", 1'b0, 2, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_x", obs_x, 0);
        check("ar_y", obs_y, 0);
        check("ar_valid", obs_v, 0);
        check("ar_done", obs_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_idle_valid", obs_v, 0);
        check("ar_idle_done", obs_d, 0);

        // Full-range diagonal on the 8-bit instance
        sel8 = 1'b1;
        start_line("w8", -128, -128, 127, 127);
        ex = {};
        ey = {};
        for (int i = -128; i <= 127; i++) begin
            ex.push_back(i);
            ey.push_back(i);
        end
        run_line("w8", 1'b0, 256, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
